// File: rtl/prog_loader.sv
// prog_loader: boot loader filling instruction memory from a byte stream, then releasing the CPU (optional checksum: PROG_LOADER_CHECKSUM_EN)
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, FINISH, RUN, ERR} state_t;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t TAIL     = CSUM;
    localparam logic   TAIL_RDY = 1'b1;
`else
    localparam state_t TAIL     = FINISH;
    localparam logic   TAIL_RDY = 1'b0;
`endif
    localparam logic [16:0] MAX_N = 17'(MEM_DEPTH);
    state_t      state_q;
    logic [7:0]  cnt_lo_q;
    logic [15:0] n_q;
    logic [15:0] idx_q;
    logic [1:0]  bidx_q;
    logic [23:0] asm_q;
    logic        fire;
    logic [15:0] n_hdr;
    assign fire  = in_valid && in_ready;
    assign n_hdr = {in_data, cnt_lo_q};
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    // running XOR over header and payload bytes, compared against the trailing byte
    always_ff @(posedge clk) begin
        if (rst)
            csum_q <= 8'd0;
        else if (fire && (state_q == HDR0 || state_q == HDR1 || state_q == DATA))
            csum_q <= csum_q ^ in_data;
    end
`endif
    // loader FSM with registered handshake, write-port and CPU-control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HDR0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            cnt_lo_q   <= 8'd0;
            n_q        <= 16'd0;
            idx_q      <= 16'd0;
            bidx_q     <= 2'd0;
            asm_q      <= 24'd0;
        end else begin
            imem_we <= 1'b0;
            case (state_q)
                HDR0: begin
                    in_ready <= 1'b1;
                    if (fire) begin
                        cnt_lo_q <= in_data;
                        state_q  <= HDR1;
                    end
                end
                HDR1: if (fire) begin
                    n_q    <= n_hdr;
                    idx_q  <= 16'd0;
                    bidx_q <= 2'd0;
                    if ({1'b0, n_hdr} > MAX_N) begin
                        state_q  <= ERR;
                        in_ready <= 1'b0;
                        err      <= 1'b1;
                    end else if (n_hdr == 16'd0) begin
                        state_q  <= TAIL;
                        in_ready <= TAIL_RDY;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (fire) begin
                    bidx_q <= bidx_q + 2'd1;
                    asm_q  <= {in_data, asm_q[23:8]};
                    if (bidx_q == 2'd3) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= idx_q[ADDR_W-1:0];
                        imem_wdata <= {in_data, asm_q};
                        idx_q      <= idx_q + 16'd1;
                        if (idx_q + 16'd1 == n_q) begin
                            state_q  <= TAIL;
                            in_ready <= TAIL_RDY;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM: if (fire) begin
                    in_ready <= 1'b0;
                    if (in_data == csum_q) begin
                        state_q <= FINISH;
                    end else begin
                        state_q <= ERR;
                        err     <= 1'b1;
                    end
                end
`endif
                FINISH: begin
                    state_q <= RUN;
                    cpu_rst <= 1'b0;
                    done    <= 1'b1;
                end
                RUN: ;
                ERR: ;
                default: begin
                    state_q  <= ERR;
                    in_ready <= 1'b0;
                    err      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    int          total = 0;
    int          bad = 0;
    logic [39:0] wq[$];
    logic [7:0]  st[$];

    prog_loader #(.ADDR_W(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // every strobe seen mid-cycle is logged as {addr, data}
    always @(negedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_cpurst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        while (!in_ready && n < 1000) begin
            tick();
            n++;
        end
        check("ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_all(input int maxgap);
        foreach (st[i]) send_byte(st[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic check_n2_writes(input string tag);
        check({tag, "_nw"}, 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check({tag, "_a0"}, 32'(wq[0][39:32]), 32'd0);
            check({tag, "_d0"}, wq[0][31:0], 32'h00500013);
            check({tag, "_a1"}, 32'(wq[1][39:32]), 32'd1);
            check({tag, "_d1"}, wq[1][31:0], 32'h00A00093);
        end
    endtask

    initial begin
        int bad_cycles;
        tick();
        tick();
        check_reset_vals("rst");
        rst = 1'b0;
        tick();
        check("rdy_after_rst", 32'(in_ready), 32'd1);

        // N=2 back-to-back
        do_reset();
        st = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        send_all(0);
        check("n2_last_we", 32'(imem_we), 32'd1);
        check("n2_last_addr", 32'(imem_addr), 32'd1);
        check("n2_last_data", imem_wdata, 32'h00A00093);
        check("n2_fin_cpurst", 32'(cpu_rst), 32'd1);
        check("n2_fin_rdy", 32'(in_ready), 32'd0);
        tick();
        check("n2_run_cpurst", 32'(cpu_rst), 32'd0);
        check("n2_run_done", 32'(done), 32'd1);
        check("n2_run_we", 32'(imem_we), 32'd0);
        check("n2_run_err", 32'(err), 32'd0);
        check_n2_writes("n2");

        // N=0
        do_reset();
        st = '{8'h00, 8'h00};
        send_all(0);
        check("n0_fin_cpurst", 32'(cpu_rst), 32'd1);
        check("n0_fin_done", 32'(done), 32'd0);
        tick();
        check("n0_run_cpurst", 32'(cpu_rst), 32'd0);
        check("n0_run_done", 32'(done), 32'd1);
        check("n0_nw", 32'(wq.size()), 32'd0);

        // N=257 overflows the memory
        do_reset();
        st = '{8'h01, 8'h01};
        send_all(0);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_rdy", 32'(in_ready), 32'd0);
        check("ovf_cpurst", 32'(cpu_rst), 32'd1);
        in_valid = 1'b1;
        in_data = 8'h5A;
        bad_cycles = 0;
        repeat (100) begin
            tick();
            if (!cpu_rst || in_ready || imem_we || !err || done) bad_cycles++;
        end
        in_valid = 1'b0;
        check("ovf_hold", 32'(bad_cycles), 32'd0);
        check("ovf_nw", 32'(wq.size()), 32'd0);

        // N=2 with random input gaps
        do_reset();
        st = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        send_all(3);
        tick();
        check("gap_done", 32'(done), 32'd1);
        check_n2_writes("gap");

        // reset mid-stream, then full N=1 load
        do_reset();
        st = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93};
        send_all(0);
        check("mid_cpurst", 32'(cpu_rst), 32'd1);
        check("mid_nw", 32'(wq.size()), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_vals("mid_rst");
        rst = 1'b0;
        wq.delete();
        st = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_all(0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("re_csum_rdy", 32'(in_ready), 32'd1);
        send_byte(8'h01 ^ 8'h00 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE, 0);
`endif
        check("re_fin_cpurst", 32'(cpu_rst), 32'd1);
        tick();
        check("re_done", 32'(done), 32'd1);
        check("re_cpurst", 32'(cpu_rst), 32'd0);
        check("re_nw", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) begin
            check("re_a0", 32'(wq[0][39:32]), 32'd0);
            check("re_d0", wq[0][31:0], 32'hDEADBEEF);
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        // bad checksum: word written, CPU held in reset
        do_reset();
        st = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_all(0);
        send_byte(8'h02, 0);
        tick();
        check("cs_bad_err", 32'(err), 32'd1);
        check("cs_bad_cpurst", 32'(cpu_rst), 32'd1);
        check("cs_bad_done", 32'(done), 32'd0);
        check("cs_bad_nw", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) check("cs_bad_d0", wq[0][31:0], 32'hDEADBEEF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
